// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU op codes, funct codes,
// multiplier FSM state encoding and forward-select codes.
package ex_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ORI   = 2'b11;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] FWD_ID    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  function automatic logic is_mult(input logic [1:0] alu_op, input logic [5:0] funct);
    return (alu_op == ALU_RTYPE) && (funct == F_MULT);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational operation decode and ALU. Unsupported functs (including
// mult, which is produced by the multiplier FSM instead) give result 0.
module ex_alu
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Decode Alu_Op/funct and compute the result.
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_ORI: result = a | b;
      default: begin
        case (funct)
          F_ADD:   result = a + b;
          F_SUB:   result = a - b;
          F_AND:   result = a & b;
          F_OR:    result = a | b;
          F_SLT:   result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
          F_SLL:   result = b << shamt;
          F_SRL:   result = b >> shamt;
          default: result = '0;
        endcase
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mux3x1.sv
// Three-way operand forward mux; the unused select code falls back to in0.
module mux3x1
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] y
);

  // Select the forwarded operand.
  always_comb begin
    y = in0;
    case (sel)
      FWD_MEMWB: y = in1;
      FWD_EXMEM: y = in2;
      default:   y = in0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM pipeline register and an
// optional iterative shift-add multiplier enabled by the EX_MULT_EN macro.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ExFlush,
  input  logic             IdEx_RegDst,
  input  logic             IdEx_MemRead,
  input  logic             IdEx_MemtoReg,
  input  logic             IdEx_MemWrite,
  input  logic             IdEx_RegWrite,
  input  logic             IdEx_ALU_Src,
  input  logic [1:0]       IdEx_Alu_Op,
  input  logic [WIDTH-1:0] IdEx_DataRs,
  input  logic [WIDTH-1:0] IdEx_DataRt,
  input  logic [WIDTH-1:0] IdEx_IMM_EX,
  input  logic [4:0]       IdEx_AddrRt,
  input  logic [4:0]       IdEx_AddrRd,
  input  logic [1:0]       Fwd_Ex_Rs,
  input  logic [1:0]       Fwd_Ex_Rt,
  input  logic [WIDTH-1:0] MemWbFwdData,
  output logic [WIDTH-1:0] ExMem_ALUResult,
  output logic [WIDTH-1:0] ExMem_DataRt,
  output logic [4:0]       ExMem_AddrRegWr,
  output logic             ExMem_Zero,
  output logic             ExMem_MemRead,
  output logic             ExMem_MemtoReg,
  output logic             ExMem_MemWrite,
  output logic             ExMem_RegWrite,
  output logic             Ex_Busy
);

  if (MUL_STEPS != WIDTH) begin : g_bad_steps
    $error("ex_stage: MUL_STEPS must equal WIDTH");
  end

  logic [WIDTH-1:0] a_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [WIDTH-1:0] product;
  logic             load_product;
  logic [WIDTH-1:0] res_next;
  logic             zero_next;

  mux3x1 #(.WIDTH(WIDTH)) u_fwd_rs (
    .sel (Fwd_Ex_Rs),
    .in0 (IdEx_DataRs),
    .in1 (MemWbFwdData),
    .in2 (ExMem_ALUResult),
    .y   (a_fwd)
  );

  mux3x1 #(.WIDTH(WIDTH)) u_fwd_rt (
    .sel (Fwd_Ex_Rt),
    .in0 (IdEx_DataRt),
    .in1 (MemWbFwdData),
    .in2 (ExMem_ALUResult),
    .y   (rt_fwd)
  );

  assign b_op = IdEx_ALU_Src ? IdEx_IMM_EX : rt_fwd;

  ex_alu #(.WIDTH(WIDTH)) u_alu (
    .alu_op (IdEx_Alu_Op),
    .funct  (IdEx_IMM_EX[5:0]),
    .shamt  (IdEx_IMM_EX[10:6]),
    .a      (a_fwd),
    .b      (b_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

`ifdef EX_MULT_EN
  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic             mult_hit;

  assign mult_hit     = is_mult(IdEx_Alu_Op, IdEx_IMM_EX[5:0]);
  assign Ex_Busy      = ((state == ST_IDLE) && mult_hit && !ExFlush) || (state == ST_BUSY);
  assign load_product = (state == ST_DONE);
  assign product      = prod;

  // Multiplier FSM: latch operands, one shift-add step per cycle, then hand off.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (ExFlush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mult_hit) begin
            mcand  <= a_fwd;
            mplier <= b_op;
            prod   <= '0;
            cnt    <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          prod   <= prod + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(MUL_STEPS - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign Ex_Busy      = 1'b0;
  assign load_product = 1'b0;
  assign product      = '0;
`endif

  assign res_next  = load_product ? product : alu_result;
  assign zero_next = load_product ? (product == '0) : alu_zero;

  // EX/MEM register: bubble on flush or while busy (data fields hold).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ExMem_ALUResult <= '0;
      ExMem_DataRt    <= '0;
      ExMem_AddrRegWr <= '0;
      ExMem_Zero      <= 1'b0;
      ExMem_MemRead   <= 1'b0;
      ExMem_MemtoReg  <= 1'b0;
      ExMem_MemWrite  <= 1'b0;
      ExMem_RegWrite  <= 1'b0;
    end else if (ExFlush || Ex_Busy) begin
      ExMem_MemRead  <= 1'b0;
      ExMem_MemtoReg <= 1'b0;
      ExMem_MemWrite <= 1'b0;
      ExMem_RegWrite <= 1'b0;
    end else begin
      ExMem_ALUResult <= res_next;
      ExMem_DataRt    <= rt_fwd;
      ExMem_AddrRegWr <= IdEx_RegDst ? IdEx_AddrRd : IdEx_AddrRt;
      ExMem_Zero      <= zero_next;
      ExMem_MemRead   <= IdEx_MemRead;
      ExMem_MemtoReg  <= IdEx_MemtoReg;
      ExMem_MemWrite  <= IdEx_MemWrite;
      ExMem_RegWrite  <= IdEx_RegWrite;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, directed flush
// and multiplier sequences (EX_MULT_EN builds), and a randomized run
// against a behavioural model.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ExFlush;
  logic        IdEx_RegDst, IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite;
  logic        IdEx_ALU_Src;
  logic [1:0]  IdEx_Alu_Op;
  logic [31:0] IdEx_DataRs, IdEx_DataRt, IdEx_IMM_EX;
  logic [4:0]  IdEx_AddrRt, IdEx_AddrRd;
  logic [1:0]  Fwd_Ex_Rs, Fwd_Ex_Rt;
  logic [31:0] MemWbFwdData;
  logic [31:0] ExMem_ALUResult, ExMem_DataRt;
  logic [4:0]  ExMem_AddrRegWr;
  logic        ExMem_Zero, ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite;
  logic        Ex_Busy;

  ex_stage #(.WIDTH(32), .MUL_STEPS(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .ExFlush(ExFlush),
    .IdEx_RegDst(IdEx_RegDst), .IdEx_MemRead(IdEx_MemRead), .IdEx_MemtoReg(IdEx_MemtoReg),
    .IdEx_MemWrite(IdEx_MemWrite), .IdEx_RegWrite(IdEx_RegWrite), .IdEx_ALU_Src(IdEx_ALU_Src),
    .IdEx_Alu_Op(IdEx_Alu_Op), .IdEx_DataRs(IdEx_DataRs), .IdEx_DataRt(IdEx_DataRt),
    .IdEx_IMM_EX(IdEx_IMM_EX), .IdEx_AddrRt(IdEx_AddrRt), .IdEx_AddrRd(IdEx_AddrRd),
    .Fwd_Ex_Rs(Fwd_Ex_Rs), .Fwd_Ex_Rt(Fwd_Ex_Rt), .MemWbFwdData(MemWbFwdData),
    .ExMem_ALUResult(ExMem_ALUResult), .ExMem_DataRt(ExMem_DataRt),
    .ExMem_AddrRegWr(ExMem_AddrRegWr), .ExMem_Zero(ExMem_Zero),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemtoReg(ExMem_MemtoReg),
    .ExMem_MemWrite(ExMem_MemWrite), .ExMem_RegWrite(ExMem_RegWrite), .Ex_Busy(Ex_Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic        alusrc;
    logic        regdst;
    logic [3:0]  ctrl;   // {MemRead, MemtoReg, MemWrite, RegWrite}
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [31:0] memwb;
    logic [4:0]  art;
    logic [4:0]  ard;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic [4:0]  exp_addr;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Model of what EX/MEM should hold.
  logic [31:0] exp_res, exp_rt;
  logic [4:0]  exp_addr;
  logic        exp_zero;
  logic [3:0]  exp_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] ctrl_out();
    return {ExMem_MemRead, ExMem_MemtoReg, ExMem_MemWrite, ExMem_RegWrite};
  endfunction

  // Reference ALU written from the operation table with plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    int sh;
    longint sa, sb;
    sh = int'(imm[10:6]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return a | b;
      default: begin
        case (imm[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
          6'h00: return 32'((longint'(b) * (longint'(1) << sh)) & 64'hFFFF_FFFF);
          6'h02: return 32'(longint'(b) / (longint'(1) << sh));
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] id,
                                          input logic [31:0] wb, input logic [31:0] prev);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return prev;
    return id;
  endfunction

  task automatic drive(input vec_t v);
    IdEx_Alu_Op  = v.op;
    IdEx_ALU_Src = v.alusrc;
    IdEx_RegDst  = v.regdst;
    {IdEx_MemRead, IdEx_MemtoReg, IdEx_MemWrite, IdEx_RegWrite} = v.ctrl;
    Fwd_Ex_Rs    = v.frs;
    Fwd_Ex_Rt    = v.frt;
    IdEx_DataRs  = v.rs;
    IdEx_DataRt  = v.rt;
    IdEx_IMM_EX  = v.imm;
    MemWbFwdData = v.memwb;
    IdEx_AddrRt  = v.art;
    IdEx_AddrRd  = v.ard;
  endtask

  task automatic check_regs(input string tag, input logic chk_zero);
    chk({tag, ".result"}, ExMem_ALUResult, exp_res);
    chk({tag, ".datart"}, ExMem_DataRt, exp_rt);
    chk({tag, ".addr"}, 32'(ExMem_AddrRegWr), 32'(exp_addr));
    chk({tag, ".ctrl"}, 32'(ctrl_out()), 32'(exp_ctrl));
    if (chk_zero) chk({tag, ".zero"}, 32'(ExMem_Zero), 32'(exp_zero));
  endtask

  vec_t tbl[11];

  initial begin
    vec_t v;
    logic [5:0] f;
    logic [31:0] a, rtv, b;
    logic fl;
    int busy_cycles;

    tbl[0]  = '{2'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd0, 32'h0, 32'h0, 32'h10, 32'h0, 5'd4, 5'd8, 32'h10, 1'b0, 5'd4};
    tbl[1]  = '{2'd0, 1'b1, 1'b1, 4'b1101, 2'd2, 2'd0, 32'hDEAD, 32'h0, 32'h4, 32'h0, 5'd4, 5'd12, 32'h14, 1'b0, 5'd12};
    tbl[2]  = '{2'd2, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd0, 32'h5, 32'h7, 32'h22, 32'h0, 5'd2, 5'd9, 32'hFFFF_FFFE, 1'b0, 5'd9};
    tbl[3]  = '{2'd2, 1'b0, 1'b0, 4'b0001, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1, 32'h2A, 32'h0, 5'd6, 5'd1, 32'h1, 1'b0, 5'd6};
    tbl[4]  = '{2'd2, 1'b0, 1'b0, 4'b0011, 2'd0, 2'd0, 32'h0, 32'h3, 32'h100, 32'h0, 5'd7, 5'd0, 32'h30, 1'b0, 5'd7};
    tbl[5]  = '{2'd1, 1'b0, 1'b1, 4'b0010, 2'd0, 2'd0, 32'h7, 32'h7, 32'h0, 32'h0, 5'd0, 5'd10, 32'h0, 1'b1, 5'd10};
    tbl[6]  = '{2'd2, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd1, 32'hA0, 32'h1234, 32'h25, 32'h55, 5'd0, 5'd11, 32'hF5, 1'b0, 5'd11};
    tbl[7]  = '{2'd2, 1'b0, 1'b1, 4'b1001, 2'd0, 2'd0, 32'h5, 32'h6, 32'h3F, 32'h0, 5'd0, 5'd13, 32'h0, 1'b1, 5'd13};
    tbl[8]  = '{2'd2, 1'b0, 1'b0, 4'b0001, 2'd3, 2'd3, 32'h0, 32'h8000_0000, 32'h7C2, 32'h0, 5'd14, 5'd0, 32'h1, 1'b0, 5'd14};
    tbl[9]  = '{2'd2, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd0, 32'hF0F0, 32'hFF00, 32'h24, 32'h0, 5'd0, 5'd15, 32'hF000, 1'b0, 5'd15};
    tbl[10] = '{2'd3, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd0, 32'h1200, 32'h0, 32'h34, 32'h0, 5'd16, 5'd0, 32'h1234, 1'b0, 5'd16};

    // Reset with random inputs; avoid a mult encoding so Ex_Busy is defined as 0.
    #1;
    RST_N = 1'b0;
    ExFlush = 1'($urandom);
    v = '{2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
          $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 32'h0, 1'b0, 5'd0};
    if (v.imm[5:0] == 6'h18) v.imm[5:0] = 6'h20;
    drive(v);
    tick();
    chk("reset.result", ExMem_ALUResult, 32'h0);
    chk("reset.datart", ExMem_DataRt, 32'h0);
    chk("reset.addr", 32'(ExMem_AddrRegWr), 32'h0);
    chk("reset.zero", 32'(ExMem_Zero), 32'h0);
    chk("reset.ctrl", 32'(ctrl_out()), 32'h0);
    chk("reset.busy", 32'(Ex_Busy), 32'h0);
    RST_N = 1'b1;
    ExFlush = 1'b0;

    exp_res = 32'h0;
    // Directed vectors; results chain through EX/MEM forwarding.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i]);
      exp_rt = fwd_val(tbl[i].frt, tbl[i].rt, tbl[i].memwb, exp_res);
      tick();
      exp_res  = tbl[i].exp_res;
      exp_zero = tbl[i].exp_zero;
      exp_addr = tbl[i].exp_addr;
      exp_ctrl = tbl[i].ctrl;
      check_regs($sformatf("vec%0d", i), 1'b1);
    end

    // Flush: controls bubble, data fields hold.
    v = tbl[0];
    v.ctrl = 4'b1111;
    v.imm = 32'h77;
    drive(v);
    ExFlush = 1'b1;
    tick();
    exp_ctrl = 4'b0000;
    check_regs("flush", 1'b0);
    ExFlush = 1'b0;

    // Randomized run against the reference model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 8))
        0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25;
        4: f = 6'h2A; 5: f = 6'h00; 6: f = 6'h02; 7: f = 6'h18;
        default: f = 6'($urandom);
      endcase
`ifdef EX_MULT_EN
      if (f == 6'h18) f = 6'h3F;
`endif
      v = '{2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 32'h0, 1'b0, 5'd0};
      v.imm[5:0] = f;
      fl = ($urandom_range(0, 7) == 0);
      drive(v);
      ExFlush = fl;
      a   = fwd_val(v.frs, v.rs, v.memwb, exp_res);
      rtv = fwd_val(v.frt, v.rt, v.memwb, exp_res);
      b   = v.alusrc ? v.imm : rtv;
      #1;
      chk("rand.busy", 32'(Ex_Busy), 32'h0);
      tick();
      if (fl) begin
        exp_ctrl = 4'b0000;
      end else begin
        exp_res  = ref_alu(v.op, a, b, v.imm);
        exp_zero = (exp_res == 32'h0);
        exp_rt   = rtv;
        exp_addr = v.regdst ? v.ard : v.art;
        exp_ctrl = v.ctrl;
      end
      check_regs("rand", !fl);
    end
    ExFlush = 1'b0;

`ifdef EX_MULT_EN
    // Mult: 33 busy cycles of bubbles, then the product with held controls.
    v = '{2'd2, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd0, 32'h12345, 32'h10, 32'h18, 32'h0, 5'd2, 5'd3,
          32'h0, 1'b0, 5'd0};
    drive(v);
    #1;
    busy_cycles = 0;
    while (Ex_Busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
      Fwd_Ex_Rs = 2'd1;          // late forwarding change must be ignored
      MemWbFwdData = $urandom;
      #1;
      chk("mult.bubble", 32'(ExMem_RegWrite), 32'h0);
    end
    chk("mult.busy_cycles", 32'(busy_cycles), 32'd33);
    tick();
    chk("mult.result", ExMem_ALUResult, 32'h123450);
    chk("mult.regwrite", 32'(ExMem_RegWrite), 32'h1);
    chk("mult.addr", 32'(ExMem_AddrRegWr), 32'd3);
    chk("mult.datart", ExMem_DataRt, 32'h10);
    chk("mult.zero", 32'(ExMem_Zero), 32'h0);
    v = tbl[0];
    v.ctrl = 4'b0000;
    drive(v);
    tick();

    // Mult aborted by a flush during the busy phase.
    v = '{2'd2, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd0, 32'h3, 32'h5, 32'h18, 32'h0, 5'd2, 5'd4,
          32'h0, 1'b0, 5'd0};
    drive(v);
    for (int k = 0; k < 10; k++) tick();
    ExFlush = 1'b1;
    #1;
    chk("mflush.busy_before", 32'(Ex_Busy), 32'h1);
    tick();
    chk("mflush.ctrl", 32'(ctrl_out()), 32'h0);
    chk("mflush.busy_after", 32'(Ex_Busy), 32'h0);
    ExFlush = 1'b0;
    v = tbl[0];
    v.ctrl = 4'b0000;
    drive(v);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("mflush.no_regwrite", 32'(ExMem_RegWrite), 32'h0);
      chk("mflush.idle", 32'(Ex_Busy), 32'h0);
    end
`else
    // Without the multiplier, funct 0x18 is an unsupported single-cycle op.
    v = '{2'd2, 1'b0, 1'b1, 4'b0001, 2'd0, 2'd0, 32'h12345, 32'h10, 32'h18, 32'h0, 5'd2, 5'd3,
          32'h0, 1'b0, 5'd0};
    drive(v);
    #1;
    chk("nomult.busy", 32'(Ex_Busy), 32'h0);
    tick();
    chk("nomult.result", ExMem_ALUResult, 32'h0);
    chk("nomult.regwrite", 32'(ExMem_RegWrite), 32'h1);
    chk("nomult.zero", 32'(ExMem_Zero), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
